// File: rtl/alu_arbiter.sv
// Two-requester round-robin ALU with a one-stage pipeline and an in-order result FIFO.
// Optional divider enabled by defining ALU_ARBITER_DIV_EN.
module alu_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       res_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_e;

    typedef struct packed {
        logic [7:0] data;
        logic       id;
        logic       err;
    } res_t;

    logic          rr;
    logic          s1_valid;
    logic [3:0]    s1_a;
    logic [3:0]    s1_b;
    op_e           s1_op;
    logic          s1_id;

    res_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    logic          pop;
    logic          space;
    logic          acc0;
    logic          acc1;
    logic          accept;
    res_t          alu_res;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Space counts everything accepted but not yet popped, so a full FIFO
    // plus an occupied stage 1 can never overflow on the following push.
    assign res_valid  = (fifo_count != '0);
    assign pop        = res_valid & res_ready;
    assign space      = (int'(fifo_count) + int'(s1_valid) - int'(pop)) < DEPTH;
    assign req0_ready = rst_n & space & (~req1_valid | rr);
    assign req1_ready = rst_n & space & (~req0_valid | ~rr);
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign accept     = acc0 | acc1;

    assign res_data = res_valid ? mem[rd_ptr].data : '0;
    assign res_id   = res_valid ? mem[rd_ptr].id   : 1'b0;
    assign res_err  = res_valid ? mem[rd_ptr].err  : 1'b0;

    // NOTE: every field gets a default before the case so no latch is inferred.
    always_comb begin
        alu_res    = '0;
        alu_res.id = s1_id;
        unique case (s1_op)
            OP_ADD: alu_res.data = {4'b0, s1_a} + {4'b0, s1_b};
            OP_SUB: alu_res.data = {4'b0, s1_a} - {4'b0, s1_b};
            OP_AND: alu_res.data = {4'b0, s1_a & s1_b};
            OP_OR:  alu_res.data = {4'b0, s1_a | s1_b};
            OP_XOR: alu_res.data = {4'b0, s1_a ^ s1_b};
            OP_NOT: alu_res.data = {~s1_b, ~s1_a};
            OP_MUL: alu_res.data = {4'b0, s1_a} * {4'b0, s1_b};
            OP_DIV: begin
`ifdef ALU_ARBITER_DIV_EN
                if (s1_b == 4'd0) alu_res.err  = 1'b1;
                else              alu_res.data = {4'b0, s1_a / s1_b};
`else
                alu_res.err = 1'b1;
`endif
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr         <= 1'b1;
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_ADD;
            s1_id      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                rr    <= acc1;
                s1_id <= acc1;
                s1_a  <= acc1 ? req1_a : req0_a;
                s1_b  <= acc1 ? req1_b : req0_b;
                s1_op <= op_e'(acc1 ? req1_op : req0_op);
            end
            if (s1_valid) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)      rd_ptr <= ptr_inc(rd_ptr);
            unique case ({s1_valid, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only visible through fifo_count.
    always_ff @(posedge clk) begin
        if (s1_valid) mem[wr_ptr] <= alu_res;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a queue-based transaction model.
// Honours ALU_ARBITER_DIV_EN the same way as the design.
module tb_alu_arbiter;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic       res_valid, res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_id, res_err;

    alu_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_err(res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       id;
        logic       err;
        int         edge_n;
    } entry_t;

    entry_t q[$];
    logic   m_rr = 1'b1;
    int     edge_count = 0;
    int     checks = 0;
    int     failures = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {err, data} straight from the opcode definitions.
    function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
        int   r = 0;
        logic e = 1'b0;
        case (op)
            0: r = a + b;
            1: r = (a - b + 256) % 256;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (15 - b) * 16 + (15 - a);
            6: r = a * b;
            default: begin
`ifdef ALU_ARBITER_DIV_EN
                if (b == 0) e = 1'b1;
                else        r = a / b;
`else
                e = 1'b1;
`endif
            end
        endcase
        return {e, 8'(r)};
    endfunction

    // One clock: compare against the model, then advance the model across the edge.
    task automatic tick();
        logic   exp_valid, pop, space, r0, r1, a0, a1;
        logic [8:0] res;
        entry_t e;
        #1;
        exp_valid = (q.size() > 0) && (q[0].edge_n + 1 <= edge_count);
        pop   = exp_valid & res_ready;
        space = (q.size() - int'(pop)) < DEPTH;
        r0 = space & (!req1_valid | m_rr);
        r1 = space & (!req0_valid | !m_rr);
        check("res_valid", 8'(res_valid), 8'(exp_valid));
        check("res_data", res_data, exp_valid ? q[0].data : 8'h00);
        check("res_id", 8'(res_id), exp_valid ? 8'(q[0].id) : 8'h00);
        check("res_err", 8'(res_err), exp_valid ? 8'(q[0].err) : 8'h00);
        check("req0_ready", 8'(req0_ready), 8'(r0));
        check("req1_ready", 8'(req1_ready), 8'(r1));
        a0 = req0_valid & r0;
        a1 = req1_valid & r1;
        if (a1) res = ref_alu(int'(req1_op), int'(req1_a), int'(req1_b));
        else    res = ref_alu(int'(req0_op), int'(req0_a), int'(req0_b));
        @(posedge clk);
        edge_count++;
        if (pop) void'(q.pop_front());
        if (a0 | a1) begin
            e.data = res[7:0];
            e.err = res[8];
            e.id = a1;
            e.edge_n = edge_count;
            q.push_back(e);
            m_rr = a1;
        end
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic drive1(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    task automatic reset_check();
        rst_n = 1'b0;
        #1;
        check("rst_res_valid", 8'(res_valid), 8'h00);
        check("rst_res_data", res_data, 8'h00);
        check("rst_req0_ready", 8'(req0_ready), 8'h00);
        check("rst_req1_ready", 8'(req1_ready), 8'h00);
        q.delete();
        m_rr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive0(1'b1, 4'd1, 4'd1, 3'd0);
        drive1(1'b1, 4'd2, 4'd2, 3'd0);
        @(negedge clk);
        reset_check();

        // Single multiply with a fixed two-edge latency.
        drive0(1'b1, 4'd9, 4'd3, 3'b110);
        drive1(1'b0, 4'd0, 4'd0, 3'd0);
        res_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        check("mul_valid", 8'(res_valid), 8'h01);
        check("mul_data", res_data, 8'h1B);
        check("mul_id", 8'(res_id), 8'h00);
        repeat (2) tick();

        // Arithmetic and division corner cases, back to back.
        drive0(1'b1, 4'd3, 4'd5, 3'b001);   tick();
        drive0(1'b1, 4'hA, 4'h5, 3'b101);   tick();
        drive0(1'b1, 4'hF, 4'hF, 3'b000);   tick();
        drive0(1'b1, 4'd7, 4'd0, 3'b111);   tick();
        drive0(1'b1, 4'd13, 4'd4, 3'b111);  tick();
        req0_valid = 1'b0;
        repeat (3) tick();

        // Contention: both requesters valid continuously.
        for (int i = 0; i < 8; i++) begin
            drive0(1'b1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 6)));
            drive1(1'b1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 6)));
            tick();
        end
        drive0(1'b0, 4'd0, 4'd0, 3'd0);
        drive1(1'b0, 4'd0, 4'd0, 3'd0);
        repeat (3) tick();

        // Backpressure: requester 0 streams into a stalled consumer.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive0(1'b1, 4'(i + 1), 4'd2, 3'b000);
            tick();
        end
        #1;
        check("bp_req0_ready", 8'(req0_ready), 8'h00);
        res_ready = 1'b1;
        repeat (6) tick();

        // Reset with results queued, then a tie right after release.
        res_ready = 1'b0;
        repeat (3) tick();
        reset_check();
        res_ready = 1'b1;
        drive0(1'b1, 4'd2, 4'd3, 3'b000);
        drive1(1'b1, 4'd4, 4'd5, 3'b000);
        #1;
        check("tie_req0_ready", 8'(req0_ready), 8'h01);
        check("tie_req1_ready", 8'(req1_ready), 8'h00);
        tick();
        drive0(1'b0, 4'd0, 4'd0, 3'd0);
        drive1(1'b0, 4'd0, 4'd0, 3'd0);
        repeat (4) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive0(1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
            drive1(1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive0(1'b0, 4'd0, 4'd0, 3'd0);
        drive1(1'b0, 4'd0, 4'd0, 3'd0);
        res_ready = 1'b1;
        repeat (6) tick();
        check("drained", 8'(q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, result-FIFO entries (legal 2..4).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N presents a command.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  command from requester N accepted this edge if valid.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4  unsigned operands.
REQ-007 SHALL have ports req0_op / req1_op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 110 mul, 111 div.
REQ-008 SHALL have port res_valid  output  1  result FIFO head valid.
REQ-009 SHALL have port res_ready  input  1  consumer pops head when res_valid & res_ready.
REQ-010 SHALL have port res_data  output  8  result.
REQ-011 SHALL have port res_id  output  1  requester index that issued the result.
REQ-012 SHALL have port res_err  output  1  result flagged invalid (div error).

Function
REQ-013 SHALL compute: add a+b, sub (a-b) mod 256, and/or/xor zero-extended to 8 bits, not {~b,~a}, mul a*b, div {4'b0, a/b} (integer quotient).
REQ-014 SHALL arbitrate round-robin with 1-bit pointer rr = index of last accepted requester.
REQ-015 SHALL drive req0_ready = space & (~req1_valid | rr==1); req1_ready = space & (~req0_valid | rr==0); readies independent of own valid.
REQ-016 SHALL define space = (fifo_count + s1_valid - pop) < DEPTH, pop = res_valid & res_ready.
REQ-017 SHALL update rr only on accepting edge, to accepted index; idle cycles keep rr.
REQ-018 SHALL on accept at edge N register a, b, op, id into stage s1 (s1_valid=1).
REQ-019 SHALL at edge N+1 compute ALU on s1 and write {data, id, err} into result FIFO; res_valid high after N+1 if FIFO was empty (fixed 2-edge latency).
REQ-020 SHALL present results in strict acceptance order; FIFO read/write pointers wrap modulo DEPTH.
REQ-021 SHALL allow simultaneous push and pop in one cycle, count unchanged.
REQ-022 SHALL hold res_data/res_id/res_err stable while res_valid & ~res_ready.
REQ-023 SHALL never drop or duplicate a command; at most one accept per cycle.
REQ-024 SHALL drive res_data/res_id/res_err to 0 when res_valid=0.

Reset
REQ-025 SHALL on rst_n=0, immediately and independent of clk: s1_valid=0, fifo_count=0, pointers=0, rr=1 (requester 0 wins first tie), all outputs 0.
REQ-026 SHALL on reset mid-operation discard in-flight and queued results; none appear after release.
REQ-027 SHALL accept first command on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL use macro ALU_ARBITER_DIV_EN: defined -> op 111 divides, b==0 gives res_data 0, res_err 1, else res_err 0.
REQ-029 SHALL when ALU_ARBITER_DIV_EN undefined implement no divider; op 111 gives res_data 0, res_err 1 for any operands.
REQ-030 SHALL produce res_err 0 for opcodes 000-110 in both builds.

Verification
REQ-031 SHALL cover single op: req0 a=9,b=3,op=110, res_ready=1 -> res_valid two edges later, res_data 0x1B, res_id 0, res_err 0.
REQ-032 SHALL cover contention: both valid continuously after reset, res_ready=1 -> accept order 0,1,0,1; res_id sequence 0,1,0,1.
REQ-033 SHALL cover backpressure: res_ready=0, req0 streams, DEPTH=2 -> exactly 2 accepts then req0_ready=0; res_ready=1 -> ready reasserts, results in order, none lost.
REQ-034 SHALL cover arithmetic edges: a=3,b=5,op=001 -> 0xFE; a=0xA,b=0x5,op=101 -> 0xA5; a=0xF,b=0xF,op=000 -> 0x1E.
REQ-035 SHALL cover division: a=7,b=0,op=111 -> 0x00, res_err 1; a=13,b=4 -> 0x03, err 0 (DIV_EN) / 0x00, err 1 (no DIV_EN).
REQ-036 SHALL cover reset mid-stream: rst_n low with 2 results queued -> res_valid 0 at once; after release no stale result emitted, req0 wins first tie.
